decode_stage_hs: RTL and testbench

//  Parametrised ID stage for the MIPS32 pipeline: decodes one instruction per accepted beat into the

---
 rtl/decode_stage_hs.sv | 362 ++++++++++++++++++++++++++++++++++++
 tb/tb_decode_stage_hs.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hs.sv
// -----------------------------------------------------------------------------
// decode_stage_hs
//   MIPS32 ID stage. Decodes one instruction per accepted beat into the
//   control/operand bundle consumed by EX. Valid/ready handshake on both sides.
//   A small stall FSM holds the stage after branches and memory ops until
//   either an external resume pulse arrives (RESUME_MODE=0) or an internal
//   wait counter expires (RESUME_MODE=1).
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   in_valid/in_ready        upstream handshake (inst, pc)
//   rs_addr/rt_addr          combinational register-file read addresses
//   rs_data/rt_data          register-file read data, same cycle as inst
//   branch_resume            branch resolved in EX   (RESUME_MODE=0)
//   dmem_resume              memory access completed (RESUME_MODE=0)
//   out_valid/out_ready      downstream handshake for the *_d bundle
//   *_d                      registered control bits, operands and fields
//   stall_state              00 RUN, 01 BR_WAIT, 10 MEM_WAIT
// -----------------------------------------------------------------------------
module decode_stage_hs #(
   parameter int RESUME_MODE = 0,
   parameter int BRANCH_WAIT = 2,
   parameter int MEM_WAIT    = 3,
   parameter int ZEXT_LOGIC  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   output logic [4:0]  rs_addr,
   output logic [4:0]  rt_addr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        branch_resume,
   input  logic        dmem_resume,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        reg_write_d,
   output logic        mem_to_reg_d,
   output logic        mem_write_d,
   output logic        branch_d,
   output logic        reg_dst_d,
   output logic [3:0]  alu_control_d,
   output logic [1:0]  alu_src_d,
   output logic [3:0]  branch_type_d,
   output logic        illegal_d,
   output logic [31:0] rd1_d,
   output logic [31:0] rd2_d,
   output logic [4:0]  rs_d,
   output logic [4:0]  rt_d,
   output logic [4:0]  rd_d,
   output logic [4:0]  shamt_d,
   output logic [31:0] imm_d,
   output logic [31:0] pc_plus_4d,
   output logic [31:0] jump_addr_d,
   output logic [1:0]  stall_state
);

   // opcodes
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   // R-type functs
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_NOR  = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SLT  = 4'b1001;
   localparam logic [3:0] ALU_SLTU = 4'b1010;
   localparam logic [3:0] ALU_LUI  = 4'b1011;
   localparam logic [3:0] ALU_PASS = 4'b1110;

   // ALU B-operand select
   localparam logic [1:0] SRC_REG   = 2'b00;
   localparam logic [1:0] SRC_SHAMT = 2'b01;
   localparam logic [1:0] SRC_IMM   = 2'b10;
   localparam logic [1:0] SRC_STIMM = 2'b11;

   // branch types
   localparam logic [3:0] BT_J    = 4'd1;
   localparam logic [3:0] BT_JAL  = 4'd2;
   localparam logic [3:0] BT_JR   = 4'd3;
   localparam logic [3:0] BT_BEQ  = 4'd4;
   localparam logic [3:0] BT_BNE  = 4'd5;
   localparam logic [3:0] BT_BGEZ = 4'd6;
   localparam logic [3:0] BT_BLTZ = 4'd7;

   localparam int MAX_WAIT = (BRANCH_WAIT > MEM_WAIT) ? BRANCH_WAIT : MEM_WAIT;
   localparam int CW       = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] BR_LAST  = CW'(BRANCH_WAIT);
   localparam logic [CW-1:0] MEM_LAST = CW'(MEM_WAIT);

   typedef enum logic [1:0] {
      S_RUN = 2'b00,
      S_BR  = 2'b01,
      S_MEM = 2'b10
   } state_e;

   typedef struct packed {
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_write;
      logic        branch;
      logic        reg_dst;
      logic [3:0]  alu;
      logic [1:0]  src;
      logic [3:0]  btype;
      logic        illegal;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [31:0] jaddr;
   } bundle_t;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic          out_valid_q;
   bundle_t       bndl_q, bndl_d;
   logic          is_mem_d;
   logic          accept;

   logic [5:0] op, fn;
   assign op = inst[31:26];
   assign fn = inst[5:0];

   assign rs_addr  = inst[25:21];
   assign rt_addr  = inst[20:16];
   assign in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // ---------------------------------------------------------------- decode
   always_comb begin
      bndl_d       = '0;
      is_mem_d     = 1'b0;
      bndl_d.rd1   = rs_data;
      bndl_d.rd2   = rt_data;
      bndl_d.rs    = inst[25:21];
      bndl_d.rt    = inst[20:16];
      bndl_d.rd    = inst[15:11];
      bndl_d.shamt = inst[10:6];
      bndl_d.imm   = {{16{inst[15]}}, inst[15:0]};
      bndl_d.pc4   = pc + 32'd4;
      bndl_d.jaddr = {pc[31:28], inst[25:0], 2'b00};

      unique case (op)
         OP_RTYPE: begin
            bndl_d.reg_write = 1'b1;
            bndl_d.reg_dst   = 1'b1;
            unique case (fn)
               FN_ADD, FN_ADDU: bndl_d.alu = ALU_ADD;
               FN_SUBU:         bndl_d.alu = ALU_SUB;
               FN_AND:          bndl_d.alu = ALU_AND;
               FN_OR:           bndl_d.alu = ALU_OR;
               FN_NOR:          bndl_d.alu = ALU_NOR;
               FN_XOR:          bndl_d.alu = ALU_XOR;
               FN_SLT:          bndl_d.alu = ALU_SLT;
               FN_SLTU:         bndl_d.alu = ALU_SLTU;
               FN_SLL: begin
                  // sll $0 (which includes the all-zero nop) travels as a bubble
                  if (inst[15:11] == 5'd0) begin
                     bndl_d.reg_write = 1'b0;
                     bndl_d.reg_dst   = 1'b0;
                  end else begin
                     bndl_d.alu = ALU_SLL;
                     bndl_d.src = SRC_SHAMT;
                  end
               end
               FN_SRA: begin
                  bndl_d.alu = ALU_SRA;
                  bndl_d.src = SRC_SHAMT;
               end
               FN_SRL: begin
                  bndl_d.alu = ALU_SRL;
                  bndl_d.src = SRC_SHAMT;
               end
               FN_JR: begin
                  bndl_d.reg_write = 1'b0;
                  bndl_d.reg_dst   = 1'b0;
                  bndl_d.branch    = 1'b1;
                  bndl_d.alu       = ALU_PASS;
                  bndl_d.btype     = BT_JR;
               end
               default: begin
                  bndl_d.reg_write = 1'b0;
                  bndl_d.reg_dst   = 1'b0;
                  bndl_d.illegal   = 1'b1;
               end
            endcase
         end
         OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI: begin
            bndl_d.reg_write = 1'b1;
            bndl_d.src       = SRC_IMM;
            unique case (op)
               OP_SLTI:  bndl_d.alu = ALU_SLT;
               OP_SLTIU: bndl_d.alu = ALU_SLTU;
               OP_LUI:   bndl_d.alu = ALU_LUI;
               default:  bndl_d.alu = ALU_ADD;
            endcase
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            bndl_d.reg_write = 1'b1;
            bndl_d.src       = SRC_IMM;
            unique case (op)
               OP_ANDI: bndl_d.alu = ALU_AND;
               OP_ORI:  bndl_d.alu = ALU_OR;
               default: bndl_d.alu = ALU_XOR;
            endcase
            if (ZEXT_LOGIC != 0) bndl_d.imm = {16'h0000, inst[15:0]};
         end
         OP_LW: begin
            bndl_d.reg_write  = 1'b1;
            bndl_d.mem_to_reg = 1'b1;
            bndl_d.src        = SRC_IMM;
            is_mem_d          = 1'b1;
         end
         OP_SW: begin
            bndl_d.mem_write = 1'b1;
            bndl_d.src       = SRC_STIMM;
            is_mem_d         = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            bndl_d.branch = 1'b1;
            bndl_d.alu    = ALU_SUB;
            bndl_d.btype  = (op == OP_BEQ) ? BT_BEQ : BT_BNE;
         end
         OP_REGIMM: begin
            // only rt=0 (BLTZ) and rt=1 (BGEZ) are decodable here
            if (inst[20:17] == 4'd0) begin
               bndl_d.branch = 1'b1;
               bndl_d.alu    = ALU_PASS;
               bndl_d.btype  = inst[16] ? BT_BGEZ : BT_BLTZ;
            end else begin
               bndl_d.illegal = 1'b1;
            end
         end
         OP_J: begin
            bndl_d.branch = 1'b1;
            bndl_d.btype  = BT_J;
         end
         OP_JAL: begin
            bndl_d.branch    = 1'b1;
            bndl_d.reg_write = 1'b1;
            bndl_d.btype     = BT_JAL;
            bndl_d.rd        = 5'd31;
         end
         default: bndl_d.illegal = 1'b1;
      endcase
   end

   // ------------------------------------------------- stall FSM and bundle
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_RUN;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         bndl_q      <= '0;
      end else begin
         unique case (state_q)
            S_RUN: begin
               if (accept && (bndl_d.btype != 4'd0)) begin
                  state_q <= S_BR;
                  cnt_q   <= CW'(1);
               end else if (accept && is_mem_d) begin
                  state_q <= S_MEM;
                  cnt_q   <= CW'(1);
               end
            end
            S_BR: begin
               if (RESUME_MODE == 0) begin
                  if (branch_resume) state_q <= S_RUN;
               end else if (cnt_q == BR_LAST) begin
                  state_q <= S_RUN;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_MEM: begin
               if (RESUME_MODE == 0) begin
                  if (dmem_resume) state_q <= S_RUN;
               end else if (cnt_q == MEM_LAST) begin
                  state_q <= S_RUN;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= S_RUN;
         endcase

         // bundle only moves on accept, so it is stable under back-pressure
         if (accept) begin
            bndl_q      <= bndl_d;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid     = out_valid_q;
   assign stall_state   = state_q;
   assign reg_write_d   = bndl_q.reg_write;
   assign mem_to_reg_d  = bndl_q.mem_to_reg;
   assign mem_write_d   = bndl_q.mem_write;
   assign branch_d      = bndl_q.branch;
   assign reg_dst_d     = bndl_q.reg_dst;
   assign alu_control_d = bndl_q.alu;
   assign alu_src_d     = bndl_q.src;
   assign branch_type_d = bndl_q.btype;
   assign illegal_d     = bndl_q.illegal;
   assign rd1_d         = bndl_q.rd1;
   assign rd2_d         = bndl_q.rd2;
   assign rs_d          = bndl_q.rs;
   assign rt_d          = bndl_q.rt;
   assign rd_d          = bndl_q.rd;
   assign shamt_d       = bndl_q.shamt;
   assign imm_d         = bndl_q.imm;
   assign pc_plus_4d    = bndl_q.pc4;
   assign jump_addr_d   = bndl_q.jaddr;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Two DUTs share the clock: instance 0 uses resume pulses with zero-extended
// logical immediates, instance 1 uses the wait counters with sign extension.
// Each has its own driver/model and a decoupled scoreboard monitor.
module tb_decode_stage_hs;

   typedef struct packed {
      logic [15:0] ctrl;  // {rw,m2r,mw,br,rdst,alu[3:0],src[1:0],bt[3:0],ill}
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [19:0] fld;   // {rs,rt,rd,shamt}
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [31:0] jad;
      logic [1:0]  kind;  // 0 none, 1 branch/jump, 2 load/store
   } exp_t;

   int ncmp  = 0;
   int nerr  = 0;
   int ndone = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv, input int id);
      ncmp++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL dut%0d %s: got %h expected %h", id, nm, act, expv);
      end
   endtask

   // Reference decode written straight from the instruction table.
   function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                  input logic [31:0] a, input logic [31:0] b, input int zx);
      exp_t e;
      logic rw = 0, m2r = 0, mw = 0, br = 0, rdst = 0, ill = 0;
      logic [3:0] alu = 0, bt = 0;
      logic [1:0] src = 0;
      logic [5:0] op = i[31:26];
      logic [5:0] fn = i[5:0];
      e     = '0;
      e.rd1 = a;
      e.rd2 = b;
      e.fld = {i[25:21], i[20:16], i[15:11], i[10:6]};
      e.pc4 = p + 32'd4;
      e.jad = {p[31:28], i[25:0], 2'b00};
      e.imm = {{16{i[15]}}, i[15:0]};
      if (op == 6'h00) begin
         rw = 1; rdst = 1;
         case (fn)
            6'h20, 6'h21: alu = 4'd0;
            6'h23: alu = 4'd1;
            6'h24: alu = 4'd2;
            6'h25: alu = 4'd3;
            6'h27: alu = 4'd4;
            6'h26: alu = 4'd5;
            6'h2A: alu = 4'd9;
            6'h2B: alu = 4'd10;
            6'h00: begin alu = 4'd6; src = 2'b01; end
            6'h03: begin alu = 4'd7; src = 2'b01; end
            6'h02: begin alu = 4'd8; src = 2'b01; end
            6'h08: begin rw = 0; rdst = 0; br = 1; alu = 4'd14; bt = 4'd3; end
            default: begin rw = 0; rdst = 0; ill = 1; end
         endcase
         if (fn == 6'h00 && i[15:11] == 5'd0) begin rw = 0; rdst = 0; alu = 0; src = 0; end
      end else begin
         case (op)
            6'h09: begin rw = 1; src = 2'b10; alu = 4'd0; end
            6'h0A: begin rw = 1; src = 2'b10; alu = 4'd9; end
            6'h0B: begin rw = 1; src = 2'b10; alu = 4'd10; end
            6'h0C: begin rw = 1; src = 2'b10; alu = 4'd2; end
            6'h0D: begin rw = 1; src = 2'b10; alu = 4'd3; end
            6'h0E: begin rw = 1; src = 2'b10; alu = 4'd5; end
            6'h0F: begin rw = 1; src = 2'b10; alu = 4'd11; end
            6'h23: begin rw = 1; m2r = 1; src = 2'b10; e.kind = 2; end
            6'h2B: begin mw = 1; src = 2'b11; e.kind = 2; end
            6'h04: begin br = 1; alu = 4'd1; bt = 4'd4; end
            6'h05: begin br = 1; alu = 4'd1; bt = 4'd5; end
            6'h01: begin
               if (i[20:16] == 5'd1)      begin br = 1; alu = 4'd14; bt = 4'd6; end
               else if (i[20:16] == 5'd0) begin br = 1; alu = 4'd14; bt = 4'd7; end
               else ill = 1;
            end
            6'h02: begin br = 1; bt = 4'd1; end
            6'h03: begin br = 1; rw = 1; bt = 4'd2; e.fld[9:5] = 5'd31; end
            default: ill = 1;
         endcase
         if (zx != 0 && (op == 6'h0C || op == 6'h0D || op == 6'h0E)) e.imm = {16'h0, i[15:0]};
      end
      if (bt != 0) e.kind = 1;
      e.ctrl = {rw, m2r, mw, br, rdst, alu, src, bt, ill};
      return e;
   endfunction

   function automatic logic [31:0] rnd_inst();
      logic [31:0] w = $urandom;
      int k = $urandom_range(0, 19);
      if (k <= 7) begin
         w[31:26] = 6'h00;
         case ($urandom_range(0, 14))
            0: w[5:0] = 6'h20;  1: w[5:0] = 6'h21;  2: w[5:0] = 6'h23;
            3: w[5:0] = 6'h24;  4: w[5:0] = 6'h25;  5: w[5:0] = 6'h26;
            6: w[5:0] = 6'h27;  7: w[5:0] = 6'h2A;  8: w[5:0] = 6'h2B;
            9: begin w[5:0] = 6'h00; if ($urandom_range(0, 2) == 0) w[15:11] = 5'd0; end
            10: w[5:0] = 6'h02; 11: w[5:0] = 6'h03; 12: w[5:0] = 6'h08;
            default: ;
         endcase
      end else if (k == 8) begin
         w[31:26] = 6'h01;
         w[20:16] = 5'($urandom_range(0, 2));
      end else if (k <= 17) begin
         case ($urandom_range(0, 12))
            0: w[31:26] = 6'h02;  1: w[31:26] = 6'h03;  2: w[31:26] = 6'h04;
            3: w[31:26] = 6'h05;  4: w[31:26] = 6'h09;  5: w[31:26] = 6'h0A;
            6: w[31:26] = 6'h0B;  7: w[31:26] = 6'h0C;  8: w[31:26] = 6'h0D;
            9: w[31:26] = 6'h0E;  10: w[31:26] = 6'h0F; 11: w[31:26] = 6'h23;
            default: w[31:26] = 6'h2B;
         endcase
      end else if (k == 19) begin
         w = 32'h0;
      end
      return w;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int RM = g;
      localparam int ZX = 1 - g;
      localparam int BW = 2;
      localparam int MW = 3;

      logic        rst, in_valid, in_ready, branch_resume, dmem_resume, out_valid, out_ready;
      logic [31:0] inst, pc, rs_data, rt_data;
      logic [4:0]  rs_addr, rt_addr;
      logic        reg_write_d, mem_to_reg_d, mem_write_d, branch_d, reg_dst_d, illegal_d;
      logic [3:0]  alu_control_d, branch_type_d;
      logic [1:0]  alu_src_d, stall_state;
      logic [31:0] rd1_d, rd2_d, imm_d, pc_plus_4d, jump_addr_d;
      logic [4:0]  rs_d, rt_d, rd_d, shamt_d;

      decode_stage_hs #(.RESUME_MODE(RM), .BRANCH_WAIT(BW), .MEM_WAIT(MW), .ZEXT_LOGIC(ZX)) u_dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
         .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
         .branch_resume(branch_resume), .dmem_resume(dmem_resume),
         .out_valid(out_valid), .out_ready(out_ready),
         .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
         .branch_d(branch_d), .reg_dst_d(reg_dst_d), .alu_control_d(alu_control_d),
         .alu_src_d(alu_src_d), .branch_type_d(branch_type_d), .illegal_d(illegal_d),
         .rd1_d(rd1_d), .rd2_d(rd2_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .shamt_d(shamt_d),
         .imm_d(imm_d), .pc_plus_4d(pc_plus_4d), .jump_addr_d(jump_addr_d),
         .stall_state(stall_state)
      );

      logic [15:0] ctrl_o;
      assign ctrl_o = {reg_write_d, mem_to_reg_d, mem_write_d, branch_d, reg_dst_d,
                       alu_control_d, alu_src_d, branch_type_d, illegal_d};

      exp_t q[$];
      int   m_st = 0;   // 0 RUN, 1 BR_WAIT, 2 MEM_WAIT
      int   m_ov = 0;
      int   m_rem = 0;  // wait cycles still to spend (counter mode)
      bit   post_rst = 0;

      // One cycle: drive at negedge+2, check at +3, advance the model.
      task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                          input logic [31:0] a, input logic [31:0] b, input logic ordy,
                          input logic br, input logic dr, input logic rs_n);
         logic exp_rdy;
         int   nst;
         exp_t e;
         @(negedge clk);
         #2;
         rst = rs_n; in_valid = v; inst = i; pc = p; rs_data = a; rt_data = b;
         out_ready = ordy; branch_resume = br; dmem_resume = dr;
         #1;
         exp_rdy = (m_st == 0) && (m_ov == 0 || ordy);
         chk("in_ready", 32'(in_ready), 32'(exp_rdy), g);
         chk("stall_state", 32'(stall_state), 32'(m_st), g);
         chk("out_valid", 32'(out_valid), 32'(m_ov), g);
         chk("rs_rt_addr", 32'({rs_addr, rt_addr}), 32'(i[25:16]), g);
         if (post_rst && rs_n) begin
            chk("reset_ctrl", 32'(ctrl_o), 32'd0, g);
            chk("reset_data", rd1_d | rd2_d | imm_d | pc_plus_4d | jump_addr_d, 32'd0, g);
            post_rst = 0;
         end
         if (!rs_n) begin
            m_st = 0; m_ov = 0; m_rem = 0; q.delete(); post_rst = 1;
         end else begin
            nst = m_st;
            if (m_st != 0) begin
               if (RM != 0) begin
                  m_rem--;
                  if (m_rem == 0) nst = 0;
               end else if ((m_st == 1 && br) || (m_st == 2 && dr)) begin
                  nst = 0;
               end
            end
            if (v && exp_rdy) begin
               e = model(i, p, a, b, ZX);
               q.push_back(e);
               m_ov = 1;
               if (e.kind == 2'd1) begin nst = 1; m_rem = BW; end
               else if (e.kind == 2'd2) begin nst = 2; m_rem = MW; end
            end else if (ordy) begin
               m_ov = 0;
            end
            m_st = nst;
         end
      endtask

      task automatic idle(input logic ordy, input logic br, input logic dr);
         step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, ordy, br, dr, 1'b1);
      endtask

      // Scoreboard monitor: compares the presented bundle, pops on handshake.
      exp_t me;
      initial forever begin
         @(negedge clk);
         #4;
         if (rst === 1'b1 && out_valid === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_beat", 32'(out_valid), 32'd0, g);
            end else begin
               me = q[0];
               chk("ctrl", 32'(ctrl_o), 32'(me.ctrl), g);
               chk("rd1", rd1_d, me.rd1, g);
               chk("rd2", rd2_d, me.rd2, g);
               chk("fields", 32'({rs_d, rt_d, rd_d, shamt_d}), 32'(me.fld), g);
               chk("imm", imm_d, me.imm, g);
               chk("pc_plus_4", pc_plus_4d, me.pc4, g);
               chk("jump_addr", jump_addr_d, me.jad, g);
               if (out_ready) void'(q.pop_front());
            end
         end
      end

      initial begin
         rst = 1'b0; in_valid = 1'b0; inst = '0; pc = '0; rs_data = '0; rt_data = '0;
         out_ready = 1'b0; branch_resume = 1'b0; dmem_resume = 1'b0;
         step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
         step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
         // addu $3,$1,$2
         step(1'b1, 32'h00221821, 32'h0000_0100, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1);
         idle(1'b0, 1'b0, 1'b0);
         chk("addu_valid", 32'(out_valid), 32'd1, g);
         chk("addu_dst_alu", 32'({reg_dst_d, alu_control_d}), 32'h10, g);
         chk("addu_rd", 32'(rd_d), 32'd3, g);
         chk("addu_rd1", rd1_d, 32'd5, g);
         chk("addu_rd2", rd2_d, 32'd7, g);
         // ori / addiu with imm 0x8000
         step(1'b1, 32'h34048000, 32'h0000_0104, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
         idle(1'b0, 1'b0, 1'b0);
         chk("ori_imm", imm_d, (ZX != 0) ? 32'h0000_8000 : 32'hFFFF_8000, g);
         step(1'b1, 32'h24048000, 32'h0000_0108, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
         idle(1'b0, 1'b0, 1'b0);
         chk("addiu_imm", imm_d, 32'hFFFF_8000, g);
         // back-pressure: 3 cycles of valid input that must not be taken
         for (int c = 0; c < 3; c++)
            step(1'b1, 32'h00432021, 32'h0000_0200, 32'd9, 32'd11, 1'b0, 1'b0, 1'b0, 1'b1);
         chk("held_imm", imm_d, 32'hFFFF_8000, g);
         step(1'b1, 32'h00432021, 32'h0000_0200, 32'd9, 32'd11, 1'b1, 1'b0, 1'b0, 1'b1);
         // illegal
         step(1'b1, 32'hFC000000, 32'h0000_0300, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b1);
         idle(1'b0, 1'b0, 1'b0);
         chk("illegal_flag", 32'(illegal_d), 32'd1, g);
         chk("illegal_nostall", 32'(stall_state), 32'd0, g);
         // beq: wait exits either via counter (2) or branch_resume at t+2
         step(1'b1, 32'h10220003, 32'h0000_0400, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1);
         idle(1'b1, 1'b0, 1'b1);
         idle(1'b1, 1'b1, 1'b0);
         step(1'b1, 32'h00221821, 32'h0000_0404, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 1'b1);
         // lw: branch_resume at t+2 must be ignored, dmem_resume at t+5
         step(1'b1, 32'h8C220004, 32'h0000_0500, 32'd8, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
         idle(1'b1, 1'b0, 1'b0);
         idle(1'b1, 1'b1, 1'b0);
         idle(1'b1, 1'b0, 1'b0);
         idle(1'b1, 1'b0, 1'b0);
         idle(1'b1, 1'b0, 1'b1);
         step(1'b1, 32'h00221821, 32'h0000_0504, 32'd3, 32'd4, 1'b1, 1'b0, 1'b0, 1'b1);
         // reset while in MEM_WAIT drops the pending bundle
         step(1'b1, 32'hAC220008, 32'h0000_0600, 32'd8, 32'd9, 1'b1, 1'b0, 1'b0, 1'b1);
         idle(1'b0, 1'b0, 1'b0);
         step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         idle(1'b0, 1'b0, 1'b0);
         chk("rst_wait_valid", 32'(out_valid), 32'd0, g);
         chk("rst_wait_state", 32'(stall_state), 32'd0, g);
         // randomized traffic
         for (int c = 0; c < 700; c++)
            step($urandom_range(0, 3) != 0, rnd_inst(), $urandom, $urandom, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 99) != 0);
         for (int c = 0; c < 12; c++) idle(1'b1, 1'b1, 1'b1);
         chk("queue_drain", 32'(q.size()), 32'd0, g);
         ndone++;
      end
   end

   initial begin
      for (int c = 0; c < 20000 && ndone < 2; c++) @(posedge clk);
      if (ndone < 2) begin
         ncmp++;
         nerr++;
         $display("FAIL timeout: finished drivers %0d expected 2", ndone);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nerr);
      $finish;
   end

endmodule
